atc_runway_scheduler: RTL and testbench
=======================================

ATC_RUNWAY_SCHEDULER -- requirements
Module: atc_runway_scheduler

Interface
REQ-001 Parameter NUM_RWY, default 4, number of runways (2..8).
REQ-002 Parameter GATE_W, default 3, gate index width; NUM_GATES = 2**GATE_W.
REQ-003 Parameter TMR_W, default 4, hold-timer width.
REQ-004 Parameters WX_HOLD default 12, FUEL_HOLD default 15, OCC_CYC default 8; each SHALL be < 2**TMR_W.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  1  aircraft request present.
REQ-008 req_ready  out  1  scheduler can accept a request.
REQ-009 req_takeoff  in  1  1 = takeoff, 0 = landing.
REQ-010 emergency  in  1  emergency flag, sampled live.
REQ-011 fuel  in  2  00 normal, 01 shortage, 10/11 excess.
REQ-012 weather  in  1  1 = good, 0 = bad, sampled live.
REQ-013 gate_number  in  GATE_W  departing gate (takeoff only).
REQ-014 gate_release  in  1  pulse: gate_release_id becomes free.
REQ-015 gate_release_id  in  GATE_W  gate being freed.
REQ-016 grant_valid  out  1  one-cycle grant pulse.
REQ-017 grant_runway  out  clog2(NUM_RWY)  allocated runway.
REQ-018 grant_gate  out  GATE_W  allocated arrival gate (landing).
REQ-019 grant_gate_valid  out  1  grant_gate meaningful.
REQ-020 timer_active  out  1  hold countdown running.
REQ-021 timer_value  out  TMR_W  current hold count.
REQ-022 rwy_busy  out  NUM_RWY  per-runway occupancy.

Function
REQ-023 FSM states IDLE, HOLD, ALLOC, GRANT; req_ready SHALL be 1 only in IDLE.
REQ-024 Accept = req_valid & req_ready; req_takeoff, fuel, gate_number captured at accept.
REQ-025 From IDLE on accept: priority (emergency=1 or fuel=01) -> ALLOC; else weather=0 -> HOLD loaded WX_HOLD; else fuel[1]=1 (landing only) -> HOLD loaded FUEL_HOLD; else -> ALLOC.
REQ-026 HOLD: timer_active=1, timer_value decrements by 1 per cycle, no wrap below 0.
REQ-027 HOLD at timer_value=0: weather=0 -> reload WX_HOLD, stay HOLD; else -> ALLOC.
REQ-028 emergency=1 in any HOLD cycle -> ALLOC next cycle, timer_active=0, timer_value=0.
REQ-029 ALLOC runway choice: takeoff prefers runway (gate_number mod NUM_RWY) if free, else lowest-index free; landing takes lowest-index free.
REQ-030 ALLOC landing gate: lowest-index free gate; non-priority landing SHALL wait in ALLOC until runway and gate both free; priority landing needs only a runway, grant_gate_valid=0 if no gate free.
REQ-031 ALLOC with no free runway: stay ALLOC, no timeout.
REQ-032 GRANT: grant_valid=1 for exactly one cycle with runway/gate; then IDLE; min accept-to-grant latency 2 cycles (IDLE->ALLOC->GRANT).
REQ-033 On grant: chosen runway occupancy counter loads OCC_CYC, rwy_busy bit set; counter decrements per cycle; bit clears when counter reaches 0.
REQ-034 On grant: landing marks grant_gate occupied; takeoff frees captured gate_number.
REQ-035 gate_release frees gate_release_id next cycle; allocation in same cycle sees pre-release state; release of free gate is no-op.
REQ-036 Outputs outside GRANT: grant_valid=0, grant_runway/grant_gate/grant_gate_valid hold 0.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, all outputs 0, rwy_busy=0, all gates free, all counters 0, regardless of state.
REQ-038 Deassertion mid-request SHALL drop the request; first accept possible on first edge after release.

Verification
REQ-039 Defaults, landing, weather=1, fuel=00, all free -> grant 2 cycles after accept, runway 0, gate 0, rwy_busy=0001 for 8 cycles.
REQ-040 Landing, weather=0 throughout first hold then 1 -> timer 12..0, reload 12 once, ALLOC after second expiry, grant runway 0.
REQ-041 Landing fuel=10 weather=1; emergency=1 at timer_value=9 -> timer_active=0 next cycle, grant follows without completing hold.
REQ-042 Takeoff gate_number=5, runway 1 free -> grant_runway=1, gate 5 freed; with runway 1 busy -> grant lowest free runway.
REQ-043 All 4 runways busy, fuel=01 landing -> waits in ALLOC, granted on cycle after first rwy_busy bit clears; all gates occupied -> grant_gate_valid=0.
REQ-044 rst_n low during HOLD (timer_value=7) -> all outputs 0 asynchronously, req_ready=1 after release.

Source files
------------

// File: rtl/atc_runway_scheduler_if.sv
// Request/grant bundle between the aircraft-request side and the runway scheduler.
// The master drives requests and gate releases. The slave drives grants, hold timer status and runway occupancy.
interface atc_runway_scheduler_if #(
    parameter int NUM_RWY = 4,
    parameter int GATE_W  = 3,
    parameter int TMR_W   = 4
);
    localparam int RWY_W = (NUM_RWY > 1) ? $clog2(NUM_RWY) : 1;

    logic               req_valid;
    logic               req_ready;
    logic               req_takeoff;
    logic               emergency;
    logic [1:0]         fuel;
    logic               weather;
    logic [GATE_W-1:0]  gate_number;
    logic               gate_release;
    logic [GATE_W-1:0]  gate_release_id;
    logic               grant_valid;
    logic [RWY_W-1:0]   grant_runway;
    logic [GATE_W-1:0]  grant_gate;
    logic               grant_gate_valid;
    logic               timer_active;
    logic [TMR_W-1:0]   timer_value;
    logic [NUM_RWY-1:0] rwy_busy;

    modport master (
        output req_valid, req_takeoff, emergency, fuel, weather, gate_number,
               gate_release, gate_release_id,
        input  req_ready, grant_valid, grant_runway, grant_gate, grant_gate_valid,
               timer_active, timer_value, rwy_busy
    );

    modport slave (
        input  req_valid, req_takeoff, emergency, fuel, weather, gate_number,
               gate_release, gate_release_id,
        output req_ready, grant_valid, grant_runway, grant_gate, grant_gate_valid,
               timer_active, timer_value, rwy_busy
    );
endinterface

// File: rtl/atc_runway_scheduler.sv
// Runway/gate scheduler: accepts one aircraft at a time and may hold it for weather or fuel.
// It then allocates a runway (and an arrival gate for landings) and issues a single-cycle grant.
//
// state | meaning
// IDLE  | ready for a request
// HOLD  | hold countdown (weather or excess fuel)
// ALLOC | waiting for a free runway (and gate for normal landings)
// GRANT | one-cycle grant pulse, occupancy updated
module atc_runway_scheduler #(
    parameter int NUM_RWY   = 4,
    parameter int GATE_W    = 3,
    parameter int TMR_W     = 4,
    parameter int WX_HOLD   = 12,
    parameter int FUEL_HOLD = 15,
    parameter int OCC_CYC   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    atc_runway_scheduler_if.slave bus
);
    localparam int NUM_GATES = 2**GATE_W;
    localparam int RWY_W     = (NUM_RWY > 1) ? $clog2(NUM_RWY) : 1;
    localparam logic [TMR_W-1:0] WX_LD   = TMR_W'(WX_HOLD);
    localparam logic [TMR_W-1:0] FUEL_LD = TMR_W'(FUEL_HOLD);
    localparam logic [TMR_W-1:0] OCC_LD  = TMR_W'(OCC_CYC);

    typedef enum logic [1:0] {IDLE, HOLD, ALLOC, GRANT} state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                takeoff_q, takeoff_d;
    logic                prio_q, prio_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [RWY_W-1:0]    g_rwy_q, g_rwy_d;
    logic [GATE_W-1:0]   g_gate_q, g_gate_d;
    logic                g_gv_q, g_gv_d;
    logic [TMR_W-1:0]    occ_q [NUM_RWY];
    logic [TMR_W-1:0]    occ_d [NUM_RWY];
    logic [NUM_GATES-1:0] gate_busy_q, gate_busy_d;

    logic [NUM_RWY-1:0]  busy;
    logic                accept, grant_fire;
    logic                any_rwy, any_gate, pref_free;
    logic [RWY_W-1:0]    low_rwy, pref_rwy;
    logic [GATE_W-1:0]   low_gate;

    assign accept     = bus.req_valid & bus.req_ready;
    assign grant_fire = (state_q == GRANT);

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_RWY; r++) busy[r] = (occ_q[r] != '0);
    end

    // Descending scans leave the lowest-index free resource selected.
    always_comb begin
        any_rwy  = 1'b0;
        low_rwy  = '0;
        for (int r = NUM_RWY - 1; r >= 0; r--) begin
            if (!busy[r]) begin
                any_rwy = 1'b1;
                low_rwy = RWY_W'(r);
            end
        end
        any_gate = 1'b0;
        low_gate = '0;
        for (int g = NUM_GATES - 1; g >= 0; g--) begin
            if (!gate_busy_q[g]) begin
                any_gate = 1'b1;
                low_gate = GATE_W'(g);
            end
        end
        pref_rwy  = RWY_W'(int'(gate_q) % NUM_RWY);
        pref_free = !busy[pref_rwy];
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        takeoff_d = takeoff_q;
        prio_d    = prio_q;
        gate_d    = gate_q;
        g_rwy_d   = g_rwy_q;
        g_gate_d  = g_gate_q;
        g_gv_d    = g_gv_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (accept) begin
                    takeoff_d = bus.req_takeoff;
                    gate_d    = bus.gate_number;
                    prio_d    = bus.emergency | (bus.fuel == 2'b01);
                    if (bus.emergency | (bus.fuel == 2'b01)) begin
                        state_d = ALLOC;
                    end else if (!bus.weather) begin
                        state_d = HOLD;
                        tmr_d   = WX_LD;
                    end else if (!bus.req_takeoff && bus.fuel[1]) begin
                        state_d = HOLD;
                        tmr_d   = FUEL_LD;
                    end else begin
                        state_d = ALLOC;
                    end
                end
            end
            HOLD: begin
                if (bus.emergency) begin
                    state_d = ALLOC;
                    tmr_d   = '0;
                    prio_d  = 1'b1;
                end else if (tmr_q == '0) begin
                    if (!bus.weather) tmr_d = WX_LD;
                    else              state_d = ALLOC;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ALLOC: begin
                if (takeoff_q) begin
                    if (any_rwy) begin
                        state_d  = GRANT;
                        g_rwy_d  = pref_free ? pref_rwy : low_rwy;
                        g_gate_d = '0;
                        g_gv_d   = 1'b0;
                    end
                end else if (any_rwy && (any_gate || prio_q)) begin
                    state_d  = GRANT;
                    g_rwy_d  = low_rwy;
                    g_gate_d = any_gate ? low_gate : '0;
                    g_gv_d   = any_gate;
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Release is applied before the grant update so a fresh landing assignment is never lost.
    always_comb begin
        gate_busy_d = gate_busy_q;
        if (bus.gate_release) gate_busy_d[bus.gate_release_id] = 1'b0;
        if (grant_fire) begin
            if (takeoff_q)   gate_busy_d[gate_q]   = 1'b0;
            else if (g_gv_q) gate_busy_d[g_gate_q] = 1'b1;
        end
        for (int r = 0; r < NUM_RWY; r++) begin
            occ_d[r] = occ_q[r];
            if (grant_fire && (g_rwy_q == RWY_W'(r))) occ_d[r] = OCC_LD;
            else if (occ_q[r] != '0)                  occ_d[r] = occ_q[r] - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            takeoff_q   <= 1'b0;
            prio_q      <= 1'b0;
            gate_q      <= '0;
            g_rwy_q     <= '0;
            g_gate_q    <= '0;
            g_gv_q      <= 1'b0;
            gate_busy_q <= '0;
            for (int r = 0; r < NUM_RWY; r++) occ_q[r] <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            takeoff_q   <= takeoff_d;
            prio_q      <= prio_d;
            gate_q      <= gate_d;
            g_rwy_q     <= g_rwy_d;
            g_gate_q    <= g_gate_d;
            g_gv_q      <= g_gv_d;
            gate_busy_q <= gate_busy_d;
            for (int r = 0; r < NUM_RWY; r++) occ_q[r] <= occ_d[r];
        end
    end

    assign bus.req_ready        = (state_q == IDLE) & rst_n;
    assign bus.grant_valid      = grant_fire;
    assign bus.grant_runway     = grant_fire ? g_rwy_q  : '0;
    assign bus.grant_gate       = grant_fire ? g_gate_q : '0;
    assign bus.grant_gate_valid = grant_fire & g_gv_q;
    assign bus.timer_active     = (state_q == HOLD);
    assign bus.timer_value      = (state_q == HOLD) ? tmr_q : '0;
    assign bus.rwy_busy         = busy;
endmodule

// File: tb/tb_atc_runway_scheduler.sv
// Bench for atc_runway_scheduler: directed scenarios plus randomized traffic, checked against a timestamp-based runway/gate model.
// A second instance with a longer occupancy time is used for the case where all runways are busy.
module tb_atc_runway_scheduler;
    localparam int NR = 4, GW = 3, TW = 4, WXH = 12, FH = 15, OCC_A = 8, OCC_B = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 0, req_takeoff = 0, emergency = 0, weather = 1;
    logic [1:0]    fuel = 0;
    logic [GW-1:0] gate_number = 0, gate_release_id = 0;
    logic          gate_release = 0;
    logic          sel = 0;

    atc_runway_scheduler_if #(.NUM_RWY(NR), .GATE_W(GW), .TMR_W(TW)) bus_a ();
    atc_runway_scheduler_if #(.NUM_RWY(NR), .GATE_W(GW), .TMR_W(TW)) bus_b ();

    atc_runway_scheduler #(.NUM_RWY(NR), .GATE_W(GW), .TMR_W(TW), .WX_HOLD(WXH),
        .FUEL_HOLD(FH), .OCC_CYC(OCC_A)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    atc_runway_scheduler #(.NUM_RWY(NR), .GATE_W(GW), .TMR_W(TW), .WX_HOLD(WXH),
        .FUEL_HOLD(FH), .OCC_CYC(OCC_B)) u_dut_long (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_a.req_valid = req_valid;         assign bus_b.req_valid = req_valid;
    assign bus_a.req_takeoff = req_takeoff;     assign bus_b.req_takeoff = req_takeoff;
    assign bus_a.emergency = emergency;         assign bus_b.emergency = emergency;
    assign bus_a.fuel = fuel;                   assign bus_b.fuel = fuel;
    assign bus_a.weather = weather;             assign bus_b.weather = weather;
    assign bus_a.gate_number = gate_number;     assign bus_b.gate_number = gate_number;
    assign bus_a.gate_release = gate_release;   assign bus_b.gate_release = gate_release;
    assign bus_a.gate_release_id = gate_release_id; assign bus_b.gate_release_id = gate_release_id;

    wire          o_ready = sel ? bus_b.req_ready        : bus_a.req_ready;
    wire          o_gv    = sel ? bus_b.grant_valid      : bus_a.grant_valid;
    wire [1:0]    o_rwy   = sel ? bus_b.grant_runway     : bus_a.grant_runway;
    wire [GW-1:0] o_gate  = sel ? bus_b.grant_gate       : bus_a.grant_gate;
    wire          o_ggv   = sel ? bus_b.grant_gate_valid : bus_a.grant_gate_valid;
    wire          o_tact  = sel ? bus_b.timer_active     : bus_a.timer_active;
    wire [TW-1:0] o_tval  = sel ? bus_b.timer_value      : bus_a.timer_value;
    wire [NR-1:0] o_busy  = sel ? bus_b.rwy_busy         : bus_a.rwy_busy;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int free_at [NR];
    bit gate_occ [8];
    int occ_len = OCC_A;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) free_at[r] = 0;
        for (int k = 0; k < 8; k++) gate_occ[k] = 1'b0;
    endtask

    // A runway granted in cycle g is occupied for cycles g+1 .. g+occ_len.
    task automatic predict(input int alloc_t, input bit to, input bit prio, input int gn,
                           output int g, output int rw, output int gt, output int gv);
        int t, lr, lg;
        bit done;
        done = 0; g = -1; rw = 0; gt = 0; gv = 0; t = alloc_t;
        while (!done && t < alloc_t + 400) begin
            lr = -1; lg = -1;
            for (int r = NR - 1; r >= 0; r--) if (free_at[r] <= t) lr = r;
            for (int k = 7; k >= 0; k--) if (!gate_occ[k]) lg = k;
            if (to) begin
                if (lr >= 0) begin
                    rw = (free_at[gn % NR] <= t) ? gn % NR : lr;
                    done = 1;
                end
            end else if (lr >= 0 && (lg >= 0 || prio)) begin
                rw = lr; gv = (lg >= 0) ? 1 : 0; gt = (lg >= 0) ? lg : 0;
                done = 1;
            end
            if (done) g = t + 1;
            t++;
        end
        if (done) begin
            free_at[rw] = g + occ_len + 1;
            if (to) gate_occ[gn] = 1'b0;
            else if (gv != 0) gate_occ[gt] = 1'b1;
        end
    endtask

    task automatic send(input bit to, input bit [1:0] f, input int gn, input bit wx, output int acc);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (o_ready) break;
        end
        if (!o_ready) chk("ready_seen", int'(o_ready), 1);
        req_valid = 1; req_takeoff = to; fuel = f; gate_number = GW'(gn); weather = wx;
        acc = cyc;
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic expect_grant(input string tag, input int g, input int rw, input int gt, input int gv);
        int k;
        for (k = 0; k < 600; k++) begin
            if (o_gv) break;
            @(negedge clk);
        end
        chk({tag, "_seen"}, int'(o_gv), 1);
        if (o_gv) begin
            chk({tag, "_cyc"}, cyc, g);
            chk({tag, "_rwy"}, int'(o_rwy), rw);
            chk({tag, "_gate"}, int'(o_gate), gt);
            chk({tag, "_gv"}, int'(o_ggv), gv);
        end
    endtask

    task automatic txn(input string tag, input bit to, input bit [1:0] f, input int gn);
        int acc, at, g, rw, gt, gv;
        bit prio;
        prio = (f == 2'b01);
        send(to, f, gn, 1'b1, acc);
        at = (!prio && !to && f[1]) ? acc + 2 + FH : acc + 1;
        predict(at, to, prio, gn, g, rw, gt, gv);
        expect_grant(tag, g, rw, gt, gv);
    endtask

    task automatic release_gate(input int id);
        @(negedge clk);
        gate_release = 1; gate_release_id = GW'(id);
        @(posedge clk);
        #1 gate_release = 0;
        gate_occ[id] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(o_ready), 0);
        chk({tag, "_gv"}, int'(o_gv), 0);
        chk({tag, "_rwy"}, int'(o_rwy), 0);
        chk({tag, "_ggv"}, int'(o_ggv), 0);
        chk({tag, "_timer"}, int'({o_tact, o_tval}), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
    endtask

    initial begin
        int acc, g, rw, gt, gv, k, c, id;
        bit to, all_full;
        bit [1:0] f;

        #2 rst_n = 0;
        #1 check_reset_outputs("por");
        @(negedge clk); @(negedge clk);
        rst_n = 1; model_reset();
        @(negedge clk);
        chk("ready_after_reset", int'(o_ready), 1);

        // Plain landing: two-cycle latency, runway 0 occupied for OCC_A cycles.
        send(0, 2'b00, 0, 1, acc);
        predict(acc + 1, 0, 0, 0, g, rw, gt, gv);
        expect_grant("land_basic", g, rw, gt, gv);
        for (int i = 1; i <= OCC_A + 1; i++) begin
            @(negedge clk);
            chk($sformatf("occ_%0d", i), int'(o_busy), (i <= OCC_A) ? 1 : 0);
        end

        // Bad weather for the whole first hold: 12..0, reload, 12..0, then allocate.
        send(0, 2'b00, 0, 0, acc);
        for (int i = 0; i < 2 * (WXH + 1); i++) begin
            chk($sformatf("wx_tmr_%0d", i), int'({o_tact, o_tval}),
                16 + ((i <= WXH) ? WXH - i : 2 * WXH + 1 - i));
            if (i == WXH + 1) weather = 1;
            @(negedge clk);
        end
        chk("wx_hold_done", int'({o_tact, o_tval}), 0);
        predict(acc + 2 * (WXH + 1) + 1, 0, 0, 0, g, rw, gt, gv);
        expect_grant("wx_grant", g, rw, gt, gv);

        // Excess-fuel hold cut short by an emergency at timer value 9.
        send(0, 2'b10, 0, 1, acc);
        for (k = 0; k < 40; k++) begin
            if (o_tact && o_tval == 4'd9) break;
            @(negedge clk);
        end
        chk("fuel_hold_at9_cyc", cyc, acc + 1 + FH - 9);
        emergency = 1;
        @(negedge clk);
        emergency = 0;
        chk("emerg_timer_off", int'({o_tact, o_tval}), 0);
        predict(cyc, 0, 1, 0, g, rw, gt, gv);
        expect_grant("emerg_grant", g, rw, gt, gv);

        // Fill gates 3..7, then takeoffs from gate 5 (preferred runway 1, then busy) free gate 5.
        for (int i = 0; i < 5; i++) txn($sformatf("fill_%0d", i), 0, 2'b00, 0);
        repeat (12) @(negedge clk);
        txn("to_pref", 1, 2'b00, 5);
        txn("to_busy", 1, 2'b00, 5);
        txn("land_gate5", 0, 2'b00, 0);

        // Reset in the middle of a weather hold.
        send(0, 2'b00, 0, 0, acc);
        for (k = 0; k < 40; k++) begin
            if (o_tact && o_tval == 4'd7) break;
            @(negedge clk);
        end
        chk("hold_at7_seen", int'(o_tval), 7);
        rst_n = 0;
        #1 check_reset_outputs("mid_hold");
        @(negedge clk);
        rst_n = 1; weather = 1; model_reset();
        @(negedge clk);
        chk("ready_after_midreset", int'(o_ready), 1);
        txn("post_reset_land", 0, 2'b00, 0);

        // Randomized traffic with occasional gate releases.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) release_gate($urandom_range(0, 7));
            to = 1'($urandom_range(0, 1));
            f  = 2'($urandom_range(0, 3));
            all_full = 1;
            for (int j = 0; j < 8; j++) if (!gate_occ[j]) all_full = 0;
            if (!to && f != 2'b01 && all_full) begin
                id = $urandom_range(0, 7);
                release_gate(id);
            end
            txn($sformatf("rnd_%0d", i), to, f, $urandom_range(0, 7));
        end

        // Long-occupancy instance: all gates taken, all runways busy, priority landing waits.
        sel = 1; occ_len = OCC_B;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; model_reset();
        for (int i = 0; i < 8; i++) txn($sformatf("b_land_%0d", i), 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) txn($sformatf("b_prio_%0d", i), 0, 2'b01, 0);
        send(0, 2'b01, 0, 1, acc);
        chk("all_busy_at_alloc", int'(o_busy), 15);
        for (k = 0; k < 40; k++) begin
            if (o_busy != 4'hF) break;
            @(negedge clk);
        end
        c = cyc;
        predict(acc + 1, 0, 1, 0, g, rw, gt, gv);
        chk("grant_after_first_clear", g, c + 1);
        expect_grant("b_wait", g, rw, gt, gv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_total);
        $fatal(1, "watchdog");
    end
endmodule
